// File: rtl/score_pkg.sv
// Shared types and default constants for the score pulse generator.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned DEF_PENDING_WIDTH = 10;
  localparam int unsigned DEF_POINTS_WIDTH  = 8;
  localparam int unsigned DEF_PULSE_GAP     = 0;
  localparam int unsigned GAP_CNT_WIDTH     = 4;

endpackage

// File: rtl/score_pulse_gen.sv
// Converts credited score points into a stream of one-cycle count pulses,
// optionally spaced by PULSE_GAP idle cycles, with a saturating pending count.
module score_pulse_gen
  import score_pkg::*;
#(
  parameter int unsigned PENDING_WIDTH = DEF_PENDING_WIDTH,
  parameter int unsigned POINTS_WIDTH  = DEF_POINTS_WIDTH,
  parameter int unsigned PULSE_GAP     = DEF_PULSE_GAP
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    add_valid,
  input  logic [POINTS_WIDTH-1:0] add_points,
  input  logic                    clear,
  output logic                    count_pulse,
  output logic                    busy,
  output logic                    overflow
);

  // Wide enough for P + add_points even when add_points is wider than P.
  localparam int unsigned SUM_W =
    ((PENDING_WIDTH > POINTS_WIDTH) ? PENDING_WIDTH : POINTS_WIDTH) + 1;
  localparam logic [SUM_W-1:0] P_MAX =
    {{(SUM_W-PENDING_WIDTH){1'b0}}, {PENDING_WIDTH{1'b1}}};

  state_t                     state, state_next;
  logic [PENDING_WIDTH-1:0]   pending, pending_next;
  logic [GAP_CNT_WIDTH-1:0]   gap_cnt, gap_next;
  logic [SUM_W-1:0]           add_ext;
  logic [SUM_W-1:0]           sum;
  logic                       dec;
  logic                       sat;
  logic                       overflow_next;
  logic                       busy_next;

  // Saturating add/decrement of the pending count.
  always_comb begin
    dec          = (state == ST_PULSE);
    add_ext      = add_valid ? SUM_W'(add_points) : '0;
    sum          = SUM_W'(pending) + add_ext - {{(SUM_W-1){1'b0}}, dec};
    sat          = (sum > P_MAX);
    pending_next = sat ? '1 : sum[PENDING_WIDTH-1:0];
    if (clear) begin
      pending_next = '0;
    end
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          state_next = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (PULSE_GAP > 0) begin
          state_next = ST_GAP;
          gap_next   = GAP_CNT_WIDTH'(PULSE_GAP);
        end else if (pending_next != '0) begin
          state_next = ST_PULSE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_CNT_WIDTH'(1)) begin
          gap_next   = '0;
          state_next = (pending != '0) ? ST_PULSE : ST_IDLE;
        end else begin
          gap_next = gap_cnt - GAP_CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        gap_next   = '0;
      end
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      gap_next   = '0;
    end
  end

  always_comb begin
    overflow_next = clear ? 1'b0 : (overflow | sat);
    busy_next     = (pending_next != '0) || (state_next == ST_GAP);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      pending     <= '0;
      gap_cnt     <= '0;
      count_pulse <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      gap_cnt     <= gap_next;
      count_pulse <= (state_next == ST_PULSE);
      busy        <= busy_next;
      overflow    <= overflow_next;
    end
  end

endmodule
